// File: rtl/jtframe_led_multi.sv
// Multi-channel LED driver timed from vertical blank.
// Each channel lights directly, stretches short requests over several frames,
// or blinks at a slow or fast rate taken from a shared frame counter.
// Channel 0 is the system LED and is also forced on while the system is busy.
module jtframe_led_multi #(
  parameter int CH  = 4,
  parameter int POL = 0,
  parameter int ENW = 4,
  parameter int FW  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              LVBL,
  input  logic              sys_busy,
  input  logic [CH-1:0]     ch_req,
  input  logic [2*CH-1:0]   ch_mode,
  output logic [FW-1:0]     frame_cnt,
  output logic [CH-1:0]     led
);

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_STRETCH = 2'b01,
    MODE_SLOW    = 2'b10,
    MODE_FAST    = 2'b11
  } ledMode_e;

  localparam logic [CH-1:0]  POL_MASK = (POL != 0) ? {CH{1'b1}} : {CH{1'b0}};
  localparam logic [FW-1:0]  FONE     = FW'(1);
  localparam logic [ENW-1:0] SONE     = ENW'(1);

  logic              lastLvbl_q;
  logic              vbCen_q;
  logic [FW-1:0]     frameCnt_q, frameCnt_d;
  logic [CH-1:0]     reqL_q;
  logic [ENW-1:0]    scnt_q [CH];
  logic [ENW-1:0]    scnt_d [CH];
  logic [CH-1:0]     led_q, led_d;
  logic [CH-1:0]     rise;

  assign rise      = ch_req & ~reqL_q;
  assign frame_cnt = frameCnt_q;
  assign led       = led_q;

  // Next-state: frame counter, stretch counters (a fresh rise beats a frame tick) and LED levels
  always_comb begin
    ledMode_e  mode;
    logic [CH-1:0] lit;
    lit        = '0;
    mode       = MODE_DIRECT;
    frameCnt_d = vbCen_q ? frameCnt_q + FONE : frameCnt_q;
    for (int i = 0; i < CH; i++) begin
      scnt_d[i] = scnt_q[i];
      if (rise[i]) begin
        scnt_d[i] = '1;
      end else if (vbCen_q && (scnt_q[i] != '0)) begin
        scnt_d[i] = scnt_q[i] - SONE;
      end
      mode = ledMode_e'(ch_mode[2*i +: 2]);
      case (mode)
        MODE_DIRECT:  lit[i] = ch_req[i];
        MODE_STRETCH: lit[i] = ch_req[i] | (scnt_q[i] != '0);
        MODE_SLOW:    lit[i] = ch_req[i] & frameCnt_q[FW-1];
        MODE_FAST:    lit[i] = ch_req[i] & frameCnt_q[FW-3];
        default:      lit[i] = ch_req[i];
      endcase
    end
    lit[0] = lit[0] | sys_busy;
    led_d  = lit ^ POL_MASK;
  end

  // State registers: vblank edge detector, frame counter, request edges, stretch counters, LED pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastLvbl_q <= 1'b0;
      vbCen_q    <= 1'b0;
      frameCnt_q <= '0;
      reqL_q     <= '0;
      led_q      <= POL_MASK;
      for (int i = 0; i < CH; i++) begin
        scnt_q[i] <= '0;
      end
    end else begin
      lastLvbl_q <= LVBL;
      vbCen_q    <= ~LVBL & lastLvbl_q;
      frameCnt_q <= frameCnt_d;
      reqL_q     <= ch_req;
      led_q      <= led_d;
      for (int i = 0; i < CH; i++) begin
        scnt_q[i] <= scnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_jtframe_led_multi.sv
// Self-checking bench for jtframe_led_multi: vector table, directed
// stretch/blink/busy sequences and a randomized run against a frame-level model.
module tb_jtframe_led_multi;

  localparam int CH   = 4;
  localparam int POL  = 1;
  localparam int ENW  = 4;
  localparam int FW   = 7;
  localparam int MAXS = (1 << ENW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            LVBL;
  logic            sys_busy;
  logic [CH-1:0]   ch_req;
  logic [2*CH-1:0] ch_mode;
  logic [FW-1:0]   frame_cnt;
  logic [CH-1:0]   led;

  jtframe_led_multi #(.CH(CH), .POL(POL), .ENW(ENW), .FW(FW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .LVBL      (LVBL),
    .sys_busy  (sys_busy),
    .ch_req    (ch_req),
    .ch_mode   (ch_mode),
    .frame_cnt (frame_cnt),
    .led       (led)
  );

  // 10-unit system clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: frames counted as an integer, stretch tracked as frame ticks since the last rise
  int            mFrames;
  bit            mPrevLvbl;
  bit            mTick;
  bit [CH-1:0]   mPrevReq;
  int            mTicks [CH];
  logic [CH-1:0] mLed;

  bit lvblRun;
  int phase;

  typedef struct {
    logic [CH-1:0]   req;
    logic [2*CH-1:0] mode;
    logic            busy;
    logic [CH-1:0]   expLed;
  } vec_t;

  function automatic void modelReset();
    mFrames   = 0;
    mPrevLvbl = 1'b0;
    mTick     = 1'b0;
    mPrevReq  = '0;
    for (int i = 0; i < CH; i++) mTicks[i] = MAXS;
    mLed = (POL != 0) ? {CH{1'b1}} : {CH{1'b0}};
  endfunction

  function automatic void modelStep();
    logic [CH-1:0] lit;
    bit slowBit, fastBit;
    slowBit = ((mFrames >> (FW-1)) & 1) != 0;
    fastBit = ((mFrames >> (FW-3)) & 1) != 0;
    for (int i = 0; i < CH; i++) begin
      case (ch_mode[2*i +: 2])
        2'b00:   lit[i] = ch_req[i];
        2'b01:   lit[i] = ch_req[i] || (mTicks[i] < MAXS);
        2'b10:   lit[i] = ch_req[i] && slowBit;
        default: lit[i] = ch_req[i] && fastBit;
      endcase
    end
    if (sys_busy) lit[0] = 1'b1;
    mLed = (POL != 0) ? ~lit : lit;
    for (int i = 0; i < CH; i++) begin
      if (ch_req[i] && !mPrevReq[i]) mTicks[i] = 0;
      else if (mTick && mTicks[i] < MAXS) mTicks[i] = mTicks[i] + 1;
    end
    if (mTick) mFrames = (mFrames + 1) % (1 << FW);
    mTick     = !LVBL && mPrevLvbl;
    mPrevLvbl = LVBL;
    mPrevReq  = ch_req;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    check("led_vs_model", int'(led), int'(mLed));
    check("frame_cnt_vs_model", int'(frame_cnt), mFrames);
  endtask

  // One clock: advance the vblank generator, step the model on the edge, compare on the falling edge
  task automatic tick();
    if (lvblRun) begin
      phase = (phase + 1) % 8;
      LVBL  = (phase < 6);
    end
    @(posedge clk);
    if (rst_n) modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [CH-1:0] req, input logic [2*CH-1:0] mode,
                               input logic busy);
    ch_req   = req;
    ch_mode  = mode;
    sys_busy = busy;
    tick();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    phase = 0;
    #1;
    check("reset_led_async", int'(led), int'(mLed));
    check("reset_frame_async", int'(frame_cnt), 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Pulse ch_req[1] for one clock and count frame ticks until led[1] goes unlit
  task automatic pulseAndMeasure(output int ticks);
    int f0, n;
    ch_req[1] = 1'b1;
    tick();
    f0 = int'(frame_cnt);
    ch_req[1] = 1'b0;
    n = 0;
    while (led[1] != POL[0] && n < 600) begin
      tick();
      n++;
    end
    if (n >= 600) check("stretch_timeout", n, 0);
    ticks = (int'(frame_cnt) - f0 + (1 << FW)) % (1 << FW);
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   t, f0, n, togA, togB, fchg;
    logic prevA, prevB, frozenLed;
    logic [FW-1:0] prevF, frozenF;

    vecs[0] = '{req: 4'hF, mode: 8'h00, busy: 1'b0, expLed: 4'h0};
    vecs[1] = '{req: 4'h5, mode: 8'h00, busy: 1'b0, expLed: 4'hA};
    vecs[2] = '{req: 4'h0, mode: 8'h00, busy: 1'b1, expLed: 4'hE};
    vecs[3] = '{req: 4'hF, mode: 8'hFF, busy: 1'b0, expLed: 4'hF};
    vecs[4] = '{req: 4'hF, mode: 8'hAA, busy: 1'b1, expLed: 4'hE};
    vecs[5] = '{req: 4'hA, mode: 8'h0F, busy: 1'b0, expLed: 4'h7};
    vecs[6] = '{req: 4'h3, mode: 8'hA0, busy: 1'b0, expLed: 4'hC};

    LVBL     = 1'b1;
    lvblRun  = 1'b0;
    phase    = 0;
    ch_req   = 4'hF;
    ch_mode  = 8'h00;
    sys_busy = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // Reset with all requests high, then direct mode lights everything one clock after release
    doReset();
    check("reset_led_held", int'(led), 4'hF);
    tick();
    check("release_direct_led", int'(led), 4'h0);

    // Vector table with vblank idle (frame_cnt stays 0)
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].req, vecs[k].mode, vecs[k].busy);
      check($sformatf("vec%0d_led", k), int'(led), int'(vecs[k].expLed));
    end

    // Stretch: a 1-clock pulse keeps the LED lit for exactly 15 frame ticks
    ch_req = '0; ch_mode = 8'h04; sys_busy = 1'b0;
    doReset();
    lvblRun = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    pulseAndMeasure(t);
    check("stretch_frames", t, MAXS);

    // Retrigger at frame 10 restarts the full stretch
    for (int k = 0; k < 20; k++) tick();
    ch_req[1] = 1'b1;
    tick();
    f0 = int'(frame_cnt);
    ch_req[1] = 1'b0;
    n = 0;
    while (((int'(frame_cnt) - f0 + 128) % 128) < 10 && n < 400) begin
      tick();
      n++;
    end
    check("retrig_still_lit", int'(led[1]), int'(!POL[0]));
    pulseAndMeasure(t);
    check("retrig_stretch_frames", t, MAXS);

    // Rise in the same cycle as the frame tick must load, not decrement
    n = 0;
    while (!mTick && n < 20) begin
      tick();
      n++;
    end
    check("coincident_found", int'(mTick), 1);
    pulseAndMeasure(t);
    check("coincident_stretch_frames", t, MAXS);

    // Blink: slow on ch2, fast on ch3, 130 frames from reset
    lvblRun = 1'b0; LVBL = 1'b1;
    ch_req = 4'b1100; ch_mode = 8'hE0; sys_busy = 1'b0;
    doReset();
    lvblRun = 1'b1;
    tick();
    prevA = led[2]; prevB = led[3]; prevF = frame_cnt;
    togA = 0; togB = 0; fchg = 0; n = 0;
    while (fchg < 130 && n < 2000) begin
      tick();
      n++;
      if (frame_cnt != prevF) fchg++;
      prevF = frame_cnt;
      if (led[2] != prevA) togA++;
      if (led[3] != prevB) togB++;
      prevA = led[2]; prevB = led[3];
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      if (led[2] != prevA) togA++;
      if (led[3] != prevB) togB++;
      prevA = led[2]; prevB = led[3];
    end
    check("blink_frames_seen", fchg, 130);
    check("slow_toggles", togA, 2);
    check("fast_toggles", togB, 8);

    // sys_busy holds channel 0 lit regardless of its slow-blink mode
    lvblRun = 1'b0; LVBL = 1'b1;
    ch_req = 4'b0100; ch_mode = 8'h22; sys_busy = 1'b1;
    doReset();
    lvblRun = 1'b1;
    n = 0;
    for (int k = 0; k < 700; k++) begin
      tick();
      if (led[0] != !POL[0]) n++;
    end
    check("busy_unlit_cycles", n, 0);
    sys_busy = 1'b0;
    tick();
    check("busy_release_led0", int'(led[0]), int'(POL[0]));

    // Vblank frozen: blinking channel and frame counter stop
    lvblRun = 1'b0;
    tick(); tick();
    frozenLed = led[2]; frozenF = frame_cnt;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (led[2] != frozenLed || frame_cnt != frozenF) n++;
    end
    check("frozen_changes", n, 0);
    check("frozen_led2_lit", int'(frozenLed), int'(!POL[0]));

    // Randomized run, including a reset in the middle of activity
    lvblRun = 1'b1;
    ch_req = '0; ch_mode = $urandom; sys_busy = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(15) == 0) ch_req[i] = ~ch_req[i];
      if ($urandom_range(63) == 0) ch_mode = $urandom;
      if ($urandom_range(31) == 0) sys_busy = ~sys_busy;
      if ($urandom_range(199) == 0) lvblRun = ~lvblRun;
      if (k == 1500) doReset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
